// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag and state definitions for the ALU arbiter
// Contents: ALU opcode localparams, response flag bit indices, arbiter FSM state encoding.
package alu_pkg;

    localparam logic [4:0] ALU_MOV = 5'h00;
    localparam logic [4:0] ALU_ADD = 5'h01;
    localparam logic [4:0] ALU_SUB = 5'h02;
    localparam logic [4:0] ALU_ADC = 5'h03;
    localparam logic [4:0] ALU_SBC = 5'h04;
    localparam logic [4:0] ALU_AND = 5'h05;
    localparam logic [4:0] ALU_OR  = 5'h06;
    localparam logic [4:0] ALU_XOR = 5'h07;
    localparam logic [4:0] ALU_NOT = 5'h08;
    localparam logic [4:0] ALU_SHL = 5'h09;
    localparam logic [4:0] ALU_SHR = 5'h0A;
    localparam logic [4:0] ALU_ROL = 5'h0B;
    localparam logic [4:0] ALU_ROR = 5'h0C;
    localparam logic [4:0] ALU_INC = 5'h0D;
    localparam logic [4:0] ALU_CMP = 5'h0E;
    localparam logic [4:0] ALU_SEX = 5'h0F;

    // Response flags are packed {SIGN, CARRY, ZERO, PARITY}
    localparam int FLAGW       = 4;
    localparam int FLAG_SIGN   = 3;
    localparam int FLAG_CARRY  = 2;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_PARITY = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_grant.sv
// rtl/alu_arb_grant.sv - two-way request grant, fixed priority or round-robin
// Build option: ALU_ARB_RR_EN defined selects round-robin, otherwise requester 0 wins ties.
// Ports:
//   clk, rst_n   clock / async active-low reset (round-robin build only)
//   req_valid    per-requester request
//   enable       arbiter may grant this cycle (owner FSM idle)
//   grant        one-hot grant, zero when nothing is granted
module alu_arb_grant (
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] req_valid,
    input  logic       enable,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    // Requester granted most recently; resets to 1 so requester 0 wins the first tie
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req_valid == 2'b11)
                grant = last_grant ? 2'b01 : 2'b10;
            else
                grant = req_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
    end
`else
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            grant[0] = req_valid[0];
            grant[1] = req_valid[1] & ~req_valid[0];
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters
// Build option: ALU_ARB_RR_EN (round-robin arbitration; default fixed priority to requester 0).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/opcode/a/b[i], req_ready  per-requester request channel (i = 0,1)
//   rsp_valid[i], rsp_ack[i]            per-requester response handshake
//   rsp_result, rsp_flags, rsp_err      shared registered response payload
//   alu_opcode, alu_arga, alu_argb      registered drive to external ALU
//   alu_result, alu_sign/carry/zero/parity  ALU outputs
//   busy                                FSM not idle
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0][OPW-1:0]   req_opcode,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ack,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [FLAGW-1:0]      rsp_flags,
    output logic                  rsp_err,
    output logic [OPW-1:0]        alu_opcode,
    output logic [WIDTH-1:0]      alu_arga,
    output logic [WIDTH-1:0]      alu_argb,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_sign,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    input  logic                  alu_parity,
    output logic                  busy
);

    state_t           state;
    logic             owner;
    logic             err;
    logic [1:0]       grant;
    logic [OPW-1:0]   op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [FLAGW-1:0] alu_flags;

    alu_arb_grant u_grant (
`ifdef ALU_ARB_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .req_valid (req_valid),
        .enable    (state == IDLE),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign busy      = (state != IDLE);

    // Payload of whichever requester holds the grant this cycle
    assign op_sel = grant[1] ? req_opcode[1] : req_opcode[0];
    assign a_sel  = grant[1] ? req_a[1]      : req_a[0];
    assign b_sel  = grant[1] ? req_b[1]      : req_b[0];

    always_comb begin
        alu_flags              = '0;
        alu_flags[FLAG_SIGN]   = alu_sign;
        alu_flags[FLAG_CARRY]  = alu_carry;
        alu_flags[FLAG_ZERO]   = alu_zero;
        alu_flags[FLAG_PARITY] = alu_parity;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            err        <= 1'b0;
            alu_opcode <= '0;
            alu_arga   <= '0;
            alu_argb   <= '0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        // Illegal opcodes never reach the ALU; it sees a MOV instead
                        alu_opcode <= op_sel[OPW-1] ? '0 : op_sel;
                        alu_arga   <= a_sel;
                        alu_argb   <= b_sel;
                        err        <= op_sel[OPW-1];
                        owner      <= grant[1];
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= err ? '0 : alu_result;
                    rsp_flags  <= err ? '0 : alu_flags;
                    rsp_err    <= err;
                    rsp_valid  <= owner ? 2'b10 : 2'b01;
                    state      <= DONE;
                end
                DONE: begin
                    if (rsp_ack[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int OPW   = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            req_valid = '0;
    logic [1:0][OPW-1:0]   req_opcode = '0;
    logic [1:0][WIDTH-1:0] req_a = '0;
    logic [1:0][WIDTH-1:0] req_b = '0;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ack = '0;
    logic [WIDTH-1:0]      rsp_result;
    logic [3:0]            rsp_flags;
    logic                  rsp_err;
    logic [OPW-1:0]        alu_opcode;
    logic [WIDTH-1:0]      alu_arga;
    logic [WIDTH-1:0]      alu_argb;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_sign, alu_carry, alu_zero, alu_parity;
    logic                  busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ack    (rsp_ack),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .alu_opcode (alu_opcode),
        .alu_arga   (alu_arga),
        .alu_argb   (alu_argb),
        .alu_result (alu_result),
        .alu_sign   (alu_sign),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .alu_parity (alu_parity),
        .busy       (busy)
    );

    // Minimal external ALU: MOV/ADD/SUB, parity flag = even number of ones
    always_comb begin
        logic [16:0] wide;
        wide = 17'd0;
        case (alu_opcode)
            ALU_MOV: wide = {1'b0, alu_argb};
            ALU_ADD: wide = {1'b0, alu_arga} + {1'b0, alu_argb};
            ALU_SUB: wide = {1'b0, alu_arga} - {1'b0, alu_argb};
            default: wide = 17'd0;
        endcase
        alu_result = wide[15:0];
        alu_carry  = wide[16];
        alu_sign   = wide[15];
        alu_zero   = (wide[15:0] == 16'd0);
        alu_parity = ~^wide[15:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, wait (bounded) for its grant, drop it after the handshake edge
    task automatic send(input int r, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clk);
        req_valid[r]  = 1'b1;
        req_opcode[r] = op;
        req_a[r]      = a;
        req_b[r]      = b;
        n = 0;
        #1;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant_seen", {31'd0, req_ready[r]}, 32'd1);
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int r);
        int n;
        n = 0;
        while (!rsp_valid[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", {31'd0, rsp_valid[r]}, 32'd1);
    endtask

    task automatic ack(input int r);
        rsp_ack[r] = 1'b1;
        @(negedge clk);
        rsp_ack[r] = 1'b0;
    endtask

    initial begin
        int grants[4];
        int n;
        logic [3:0] exp_g;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_rspv",   {30'd0, rsp_valid}, 32'd0);
        check("rst_aluop",  {27'd0, alu_opcode}, 32'd0);
        check("rst_result", {16'd0, rsp_result}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: req0 ADD 3+4 with explicit latency checks
        req_valid[0] = 1'b1; req_opcode[0] = ALU_ADD; req_a[0] = 16'h0003; req_b[0] = 16'h0004;
        #1;
        check("t1_ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("t1_exec_busy", {31'd0, busy}, 32'd1);
        check("t1_exec_rspv", {30'd0, rsp_valid}, 32'd0);
        check("t1_aluop",     {27'd0, alu_opcode}, {27'd0, ALU_ADD});
        @(negedge clk);
        check("t1_rspv",   {30'd0, rsp_valid}, 32'd1);
        check("t1_result", {16'd0, rsp_result}, 32'h0007);
        check("t1_flags",  {28'd0, rsp_flags}, 32'h0);
        check("t1_err",    {31'd0, rsp_err}, 32'd0);
        ack(0);
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_rspv_clr", {30'd0, rsp_valid}, 32'd0);

        // 2: req1 SUB 1-2
        send(1, ALU_SUB, 16'h0001, 16'h0002);
        wait_rsp(1);
        check("t2_rspv",   {30'd0, rsp_valid}, 32'd2);
        check("t2_result", {16'd0, rsp_result}, 32'h0000FFFF);
        check("t2_flags",  {28'd0, rsp_flags}, 32'hD);
        ack(1);

        // 3: both requesters valid every cycle, four operations
        req_valid = 2'b11;
        req_opcode[0] = ALU_ADD; req_a[0] = 16'h0010; req_b[0] = 16'h0001;
        req_opcode[1] = ALU_ADD; req_a[1] = 16'h0020; req_b[1] = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            grants[k] = req_ready[1] ? 1 : 0;
            check("t3_onehot", {30'd0, req_ready}, req_ready[1] ? 32'd2 : 32'd1);
            @(negedge clk);
            @(negedge clk);
            check("t3_result", {16'd0, rsp_result}, grants[k] == 1 ? 32'h0022 : 32'h0011);
            rsp_ack = rsp_valid;
            @(negedge clk);
            rsp_ack = 2'b00;
        end
        req_valid = 2'b00;
`ifdef ALU_ARB_RR_EN
        exp_g = 4'b1010;
`else
        exp_g = 4'b0000;
`endif
        for (int k = 0; k < 4; k++)
            check("t3_grant", grants[k], {31'd0, exp_g[k]});

        // 4: illegal opcode
        send(0, 5'h10, 16'h0005, 16'h0006);
        check("t4_aluop", {27'd0, alu_opcode}, 32'd0);
        wait_rsp(0);
        check("t4_err",    {31'd0, rsp_err}, 32'd1);
        check("t4_result", {16'd0, rsp_result}, 32'd0);
        check("t4_flags",  {28'd0, rsp_flags}, 32'd0);
        ack(0);

        // 5: response held across ten cycles without ack; non-owner ack ignored
        send(1, ALU_ADD, 16'h8000, 16'h8000);
        wait_rsp(1);
        req_valid[0] = 1'b1; req_opcode[0] = ALU_ADD; req_a[0] = 16'h0001; req_b[0] = 16'h0001;
        rsp_ack = 2'b01;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_ready",  {30'd0, req_ready}, 32'd0);
            check("t5_busy",   {31'd0, busy}, 32'd1);
            check("t5_rspv",   {30'd0, rsp_valid}, 32'd2);
            check("t5_result", {16'd0, rsp_result}, 32'd0);
            check("t5_flags",  {28'd0, rsp_flags}, 32'h7);
        end
        rsp_ack = 2'b10;
        @(negedge clk);
        rsp_ack = 2'b00;
        req_valid = 2'b00;
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_rspv_clr", {30'd0, rsp_valid}, 32'd0);

        // 6: reset during EXEC discards the operation
        send(0, ALU_ADD, 16'h0001, 16'h0001);
        check("t6_exec", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  {31'd0, busy}, 32'd0);
        check("t6_rst_aluop", {27'd0, alu_opcode}, 32'd0);
        check("t6_rst_arga",  {16'd0, alu_arga}, 32'd0);
        check("t6_rst_rspv",  {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        send(0, ALU_ADD, 16'h0002, 16'h0001);
        wait_rsp(0);
        check("t6_result", {16'd0, rsp_result}, 32'h0003);
        check("t6_flags",  {28'd0, rsp_flags}, 32'h1);
        ack(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
